// File: rtl/serial_paralelo_rx_if.sv
// Serial receive link bundle: bit stream in, aligned bytes out.
// master drives the serial line, slave is the receiver.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: MSB-first bits to bytes,
// byte alignment locked on a run of idle commas.
module serial_paralelo_rx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  serial_paralelo_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic [7:0] assembled;
  logic       is_comma;
  logic       byte_done;
  logic [3:0] bc_inc;

  assign assembled = {sr_q[6:0], bus.data_in};
  assign is_comma  = (assembled == COMMA);
  assign byte_done = (bit_cnt_q == 3'd7);
  assign bc_inc    = {1'b0, bc_cnt_q} + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = assembled;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    unique case (state_q)
      SEARCH: begin
        // Sliding window: the comma edge becomes the byte boundary
        if (is_comma) begin
          state_d   = ALIGN;
          bc_cnt_d  = 3'd1;
          bit_cnt_d = 3'd0;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_comma) begin
            bc_cnt_d = (bc_cnt_q == 3'd7) ? 3'd7 : bc_inc[2:0];
            if (int'(bc_inc) >= LOCK_COUNT) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
              valid_d  = 1'b0;
            end
          end else begin
            state_d  = SEARCH;
            bc_cnt_d = 3'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = assembled;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

endmodule
